// File: rtl/sbqm_pkg.sv
// Shared types and constants for the SBQM wait-time stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int T_SVC_DEFAULT = 3;

    // Bits needed for the worst-case numerator T_SVC*(Pmax+Tmax-1).
    function automatic int wtime_width(input int n, input int tw, input int t_svc);
        int mx;
        int w;
        mx = t_svc * ((1 << n) - 1 + (1 << tw) - 2);
        w  = 1;
        for (int i = 0; i < 31; i++) begin
            if ((mx >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sbqm_restoring_div.sv
// Restoring divider, one quotient bit per clock, MSB first; floor result.
// Latency: WW cycles after the start edge; done is high during the final step.
// Backpressure: none; a new start reloads operands and abandons any run.
module sbqm_restoring_div #(
    parameter int WW = 5
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic          start,
    input  logic [WW-1:0] num,
    input  logic [WW-1:0] den,
    output logic [WW-1:0] quot,
    output logic          done
);

    localparam int CW = (WW > 1) ? $clog2(WW) : 1;

    logic [WW-1:0] num_r;
    logic [WW-1:0] den_r;
    logic [WW-1:0] rem;
    logic [CW-1:0] cnt;
    logic          run;
    logic [WW:0]   rem_sh;
    logic [WW:0]   rem_diff;
    logic          ge;

    assign rem_sh   = {rem, num_r[WW-1]};
    assign rem_diff = rem_sh - {1'b0, den_r};
    assign ge       = (rem_sh >= {1'b0, den_r});
    assign done     = run && (cnt == '0);

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            num_r <= '0;
            den_r <= '0;
            rem   <= '0;
            quot  <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (start) begin
            num_r <= num;
            den_r <= den;
            rem   <= '0;
            quot  <= '0;
            cnt   <= CW'(WW - 1);
            run   <= 1'b1;
        end else if (run) begin
            // After a subtract the remainder is below den, so WW bits always suffice.
            rem   <= ge ? rem_diff[WW-1:0] : rem_sh[WW-1:0];
            quot  <= {quot[WW-2:0], ge};
            num_r <= {num_r[WW-2:0], 1'b0};
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/sbqm_wait_time.sv
// Estimated wait time floor(T_SVC*(Pcount+Tcount-1)/Tcount), recomputed on input change.
// Latency: WW+2 cycles from capture (2 when Tcount==0 or Pcount==0).
// Backpressure: none; changes during a computation are picked up when it finishes.
module sbqm_wait_time
    import sbqm_pkg::*;
#(
    parameter int n     = 3,
    parameter int TW    = 2,
    parameter int T_SVC = T_SVC_DEFAULT,
    parameter int WW    = 5
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic [n-1:0]  Pcount,
    input  logic [TW-1:0] Tcount,
    output logic [WW-1:0] Wtime,
    output logic          wtime_valid,
    output logic          busy,
    output logic          no_teller
);

    if (WW < wtime_width(n, TW, T_SVC)) begin : g_ww_check
        $error("sbqm_wait_time: WW too narrow for T_SVC*(2^n-1+2^TW-2)");
    end

    state_t        state;
    logic [n-1:0]  p_snap;
    logic [TW-1:0] t_snap;
    logic [WW-1:0] spec_val;
    logic          spec_path;
    logic [WW-1:0] num;
    logic [WW-1:0] quot;
    logic          div_start;
    logic          div_done;

    assign num       = WW'(T_SVC) * (WW'(p_snap) + WW'(t_snap) - WW'(1));
    assign div_start = (state == LOAD) && (t_snap != '0) && (p_snap != '0);

    sbqm_restoring_div #(.WW(WW)) u_div (
        .clk    (clk),
        .Resetn (Resetn),
        .start  (div_start),
        .num    (num),
        .den    (WW'(t_snap)),
        .quot   (quot),
        .done   (div_done)
    );

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            Wtime       <= '0;
            wtime_valid <= 1'b1;
            busy        <= 1'b0;
            no_teller   <= 1'b0;
            p_snap      <= '0;
            t_snap      <= TW'(1);
            spec_val    <= '0;
            spec_path   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((Pcount != p_snap) || (Tcount != t_snap)) begin
                        p_snap      <= Pcount;
                        t_snap      <= Tcount;
                        wtime_valid <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (t_snap == '0) begin
                        spec_val  <= '1;
                        spec_path <= 1'b1;
                        no_teller <= 1'b1;
                        state     <= DONE;
                    end else if (p_snap == '0) begin
                        spec_val  <= '0;
                        spec_path <= 1'b1;
                        no_teller <= 1'b0;
                        state     <= DONE;
                    end else begin
                        spec_path <= 1'b0;
                        no_teller <= 1'b0;
                        state     <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) state <= DONE;
                end
                DONE: begin
                    Wtime       <= spec_path ? spec_val : quot;
                    wtime_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbqm_wait_time.sv
// Directed bench for sbqm_wait_time with hand-computed wait times and latencies.
// Latency: n/a.
// Backpressure: n/a.
module tb_sbqm_wait_time;

    logic       clk;
    logic       Resetn;
    logic [2:0] Pcount;
    logic [1:0] Tcount;
    logic [4:0] Wtime;
    logic       wtime_valid;
    logic       busy;
    logic       no_teller;

    int checks = 0;
    int errors = 0;

    sbqm_wait_time #(.n(3), .TW(2), .T_SVC(3), .WW(5)) dut (
        .clk         (clk),
        .Resetn      (Resetn),
        .Pcount      (Pcount),
        .Tcount      (Tcount),
        .Wtime       (Wtime),
        .wtime_valid (wtime_valid),
        .busy        (busy),
        .no_teller   (no_teller)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starting from IDLE with new inputs already applied: first tick is the capture edge.
    task automatic run_calc(input string tag, input int exp_lat, input int exp_w, input int exp_nt);
        int cyc;
        tick();
        chk({tag, "_busy_on_capture"}, {31'd0, busy}, 32'd1);
        chk({tag, "_valid_low"}, {31'd0, wtime_valid}, 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_wtime"}, {27'd0, Wtime}, exp_w);
        chk({tag, "_valid"}, {31'd0, wtime_valid}, 32'd1);
        chk({tag, "_no_teller"}, {31'd0, no_teller}, exp_nt);
    endtask

    initial begin
        int busy_seen;
        int wchg;
        logic [4:0] w_hold;

        Resetn = 1'b0;
        Pcount = 3'd0;
        Tcount = 2'd1;
        repeat (3) tick();
        chk("rst_wtime", {27'd0, Wtime}, 32'd0);
        chk("rst_valid", {31'd0, wtime_valid}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_no_teller", {31'd0, no_teller}, 32'd0);
        Resetn = 1'b1;
        repeat (2) tick();
        chk("idle_no_busy", {31'd0, busy}, 32'd0);

        // 3*(5+2-1)/2 = 9, busy for 7 cycles
        Pcount = 3'd5; Tcount = 2'd2;
        run_calc("p5t2", 7, 9, 0);
        // 3*(2+2-1)/2 = 4.5 -> 4
        Pcount = 3'd2; Tcount = 2'd2;
        run_calc("p2t2", 7, 4, 0);
        // 3*(7+3-1)/3 = 9
        Pcount = 3'd7; Tcount = 2'd3;
        run_calc("p7t3", 7, 9, 0);
        // 3*(1+1-1)/1 = 3
        Pcount = 3'd1; Tcount = 2'd1;
        run_calc("p1t1", 7, 3, 0);
        // empty queue
        Pcount = 3'd0; Tcount = 2'd3;
        run_calc("p0t3", 2, 0, 0);
        // no tellers: saturate
        Pcount = 3'd4; Tcount = 2'd0;
        run_calc("p4t0", 2, 31, 1);

        // Input change mid-DIV: old result 3*4/2=6 shows, then 3*5/2=7
        Pcount = 3'd3; Tcount = 2'd2;
        tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        Pcount = 3'd4;
        repeat (3) tick();
        chk("mid_still_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("mid_stale_wtime", {27'd0, Wtime}, 32'd6);
        chk("mid_stale_valid", {31'd0, wtime_valid}, 32'd1);
        chk("mid_stale_busy", {31'd0, busy}, 32'd0);
        run_calc("mid_restart", 7, 7, 0);

        // Reset mid-DIV, then same inputs recompute 3*(6+3-1)/3 = 8
        Pcount = 3'd6; Tcount = 2'd3;
        repeat (4) tick();
        chk("rmid_busy", {31'd0, busy}, 32'd1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("rmid_wtime", {27'd0, Wtime}, 32'd0);
        chk("rmid_valid", {31'd0, wtime_valid}, 32'd1);
        chk("rmid_busy_clr", {31'd0, busy}, 32'd0);
        #1;
        Resetn = 1'b1;
        run_calc("post_rst", 7, 8, 0);

        // Inputs held stable: nothing should move
        busy_seen = 0;
        wchg = 0;
        w_hold = Wtime;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
            if (Wtime !== w_hold) wchg++;
        end
        chk("stable_busy_seen", busy_seen, 32'd0);
        chk("stable_wtime_changes", wchg, 32'd0);
        chk("stable_wtime", {27'd0, Wtime}, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbqm_wait_time.md
Name: sbqm_wait_time

Overview:
- Downstream stage of the SBQM people counter.
- Consumes the queue occupancy (Pcount) and the number of open tellers (Tcount), and produces the estimated waiting time Wtime = floor(T_SVC*(Pcount+Tcount-1)/Tcount) for the display stage.
- Division is sequential: a restoring divider producing 1 bit per clock.
- The block recomputes automatically whenever either input changes.

Parameters:
- n, 3, width of Pcount; must match the counter's n.
- TW, 2, width of Tcount (max 2^TW-1 tellers).
- T_SVC, 3, service time per customer, in minutes.
- WW, 5, width of Wtime; must hold T_SVC*(2^n-1+2^TW-2); the elaboration check fails otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Pcount  in  n  queue occupancy from the counter (Y_o).
- Tcount  in  TW  number of open tellers.
- Wtime  out  WW  registered wait-time estimate, minutes.
- wtime_valid  out  1  high while Wtime reflects the current Pcount/Tcount snapshot.
- busy  out  1  high while a computation is in progress.
- no_teller  out  1  registered; high when the last snapshot had Tcount==0.

Behaviour:
- Reset (Resetn low, asynchronous): state=IDLE; Wtime=0; wtime_valid=1; busy=0; no_teller=0; snapshot registers p_snap=0, t_snap=1.
- Release from reset is treated synchronously; the first compare happens on the first rising edge after Resetn goes high.
- FSM states: IDLE, LOAD, DIV, DONE.
- IDLE:
  - Each edge, compare (Pcount,Tcount) with (p_snap,t_snap).
  - On mismatch: capture both into the snapshot, set wtime_valid=0 and busy=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - If t_snap==0: Wtime=all ones (saturated), no_teller=1, go to DONE.
  - Else if p_snap==0: Wtime=0, no_teller=0, go to DONE (an empty queue has no wait).
  - Else: num = T_SVC*(p_snap+t_snap-1), computed at WW bits with no overflow (guaranteed by the WW check); divisor = t_snap; remainder=0; bit counter=WW-1; go to DIV.
- DIV (exactly WW cycles):
  - Restoring division, MSB first.
  - Each cycle: rem = {rem, num[msb]}; if rem >= divisor then subtract and set the quotient bit to 1, else 0.
  - Exit to DONE when the bit counter reaches 0.
  - Quotient is floor; the remainder is discarded.
- DONE (1 cycle):
  - Load Wtime with the quotient (or with the LOAD value on the special paths).
  - Set wtime_valid=1, busy=0, go to IDLE.
- Latency (capture edge = cycle 0):
  - Normal path: Wtime updates at the edge of cycle WW+2.
  - Special paths (Tcount==0 or Pcount==0): Wtime updates at the edge of cycle 2.
- Input change during LOAD/DIV/DONE:
  - The computation finishes on the old snapshot; Wtime is loaded and wtime_valid pulses 1.
  - IDLE then detects the mismatch on the next edge and restarts.
  - No change is ever lost. Stale results are visible for at least 1 cycle.
- Inputs held constant: no recomputation; Wtime stable.
- Resetn asserted mid-DIV: immediate return to the reset values. The partial quotient is never output.
- Wtime changes only in DONE or on reset. Glitch-free, registered output.

Decomposition:
- sbqm_pkg:
  - state enum {IDLE, LOAD, DIV, DONE};
  - T_SVC default constant;
  - function wtime_width(n, TW, T_SVC) used for the WW elaboration check.
- Sub-module sbqm_restoring_div (parameter WW):
  - inputs start, num, den;
  - outputs quot, done;
  - owns the remainder, quotient and bit counter.
- sbqm_wait_time keeps the snapshot, compare, special-case and output registers.

Test Plan:
- Reset, then Pcount=5, Tcount=2 → busy=1 for 7 cycles; Wtime=9 at cycle 7; wtime_valid=1.
- Pcount=7, Tcount=3 → Wtime=9. Pcount=2, Tcount=2 → Wtime=4 (floor of 4.5). Pcount=1, Tcount=1 → Wtime=3.
- Pcount=0, Tcount=3 → Wtime=0 at cycle 2, no_teller=0. Then Tcount=0 with Pcount=4 → Wtime=31, no_teller=1.
- Pcount changes from 3 to 4 at cycle 3 of DIV (Tcount=2):
  - Wtime=6 is presented for 1 cycle;
  - the recompute starts automatically;
  - final Wtime=7 (15/2).
- Resetn pulled low mid-DIV: Wtime=0, wtime_valid=1 and busy=0 immediately (asynchronously). After release, with the same inputs as before reset, the block recomputes the correct value.
- Pcount and Tcount held stable for 50 cycles after a result: no busy assertion; Wtime unchanged.
